// File: rtl/cache_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_axi_pkg : shared codes and FSM encodings for the cache/AXI3 bridge   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
package cache_axi_pkg;

  localparam int AXI_ID_W = 4;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_AR   = 3'b010,
    R_DATA = 3'b100
  } rd_state_e;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_AW   = 4'b0010,
    W_DATA = 4'b0100,
    W_RESP = 4'b1000
  } wr_state_e;

  function automatic logic is_line(input logic [2:0] t);
    return t == TYPE_LINE;
  endfunction

  // Line transfers move 32-bit beats; single transfers use the low type bits.
  function automatic logic [2:0] ax_size(input logic [2:0] t);
    case (t)
      TYPE_BYTE:            return 3'd0;
      TYPE_HALF:            return 3'd1;
      TYPE_WORD, TYPE_LINE: return 3'd2;
      default:              return {1'b0, t[1:0]};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_wr_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_axi_wr_ch : write FSM, 128-bit line buffer and beat counter          |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module cache_axi_wr_ch
  import cache_axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] WR_ID    = 4'd1,
  parameter logic [7:0]          LINE_LEN = 8'd3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic [2:0]          wr_type,
  input  logic [31:0]         wr_addr,
  input  logic [3:0]          wr_wstrb,
  input  logic [127:0]        wr_data,
  output logic                wr_rdy,
  output logic                busy,
  output logic [27:0]         buf_line,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  wr_state_e    r_state;
  wr_state_e    w_next;
  logic [31:0]  r_addr;
  logic [2:0]   r_type;
  logic [3:0]   r_strb;
  logic [127:0] r_data;
  logic [1:0]   r_cnt;
  logic         w_line;

  assign w_line   = is_line(r_type);
  assign wr_rdy   = (r_state == W_IDLE);
  assign busy     = ~wr_rdy;
  assign buf_line = r_addr[31:4];

  assign awid    = WR_ID;
  assign wid     = WR_ID;
  assign awaddr  = w_line ? {r_addr[31:4], 4'h0} : r_addr;
  assign awlen   = w_line ? LINE_LEN : 8'd0;
  assign awsize  = ax_size(r_type);
  assign awburst = BURST_INCR;
  assign wstrb   = w_line ? 4'hf : r_strb;
  assign wdata   = r_data[{r_cnt, 5'b0} +: 32];

  always_ff @(posedge clk) begin
    if (rst) r_state <= W_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (wr_req && wr_rdy) begin
      r_addr <= wr_addr;
      r_type <= wr_type;
      r_strb <= wr_wstrb;
      r_data <= wr_data;
    end
    // Holding the counter at zero throughout W_AW guarantees a clean start.
    if (r_state == W_AW)                  r_cnt <= 2'd0;
    else if (r_state == W_DATA && wready) r_cnt <= r_cnt + 2'd1;
  end

  always_comb begin
    w_next  = r_state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    case (r_state)
      W_IDLE: if (wr_req) w_next = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (r_cnt == awlen[1:0]);
        if (wready && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_axi_bridge : cache read/write requests to AXI3 bursts               |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] RD_ID    = 4'd0,
  parameter logic [AXI_ID_W-1:0] WR_ID    = 4'd1,
  parameter logic [7:0]          LINE_LEN = 8'd3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [2:0]          rd_type,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic                ret_last,
  output logic [31:0]         ret_data,
  input  logic                wr_req,
  input  logic [2:0]          wr_type,
  input  logic [31:0]         wr_addr,
  input  logic [3:0]          wr_wstrb,
  input  logic [127:0]        wr_data,
  output logic                wr_rdy,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  rd_state_e   r_rd_state;
  rd_state_e   w_rd_next;
  logic [31:0] r_rd_addr;
  logic [2:0]  r_rd_type;
  logic        w_rd_line;
  logic        w_wr_busy;
  logic [27:0] w_wbuf_line;
  logic        w_unused;

  // Single outstanding transaction per channel: ids and responses carry no information.
  assign w_unused = ^{rid, rresp, bid, bresp};

  // Refilling a line that is still being written back would return stale memory.
  assign rd_rdy = (r_rd_state == R_IDLE) && !(w_wr_busy && (w_wbuf_line == rd_addr[31:4]));

  assign w_rd_line = is_line(r_rd_type);
  assign arid      = RD_ID;
  assign araddr    = w_rd_line ? {r_rd_addr[31:4], 4'h0} : r_rd_addr;
  assign arlen     = w_rd_line ? LINE_LEN : 8'd0;
  assign arsize    = ax_size(r_rd_type);
  assign arburst   = BURST_INCR;

  assign ret_valid = rready && rvalid;
  assign ret_last  = rlast;
  assign ret_data  = rdata;

  always_ff @(posedge clk) begin
    if (rst) r_rd_state <= R_IDLE;
    else     r_rd_state <= w_rd_next;
  end

  always_ff @(posedge clk) begin
    if (rd_req && rd_rdy) begin
      r_rd_addr <= rd_addr;
      r_rd_type <= rd_type;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (r_rd_state)
      R_IDLE: if (rd_req && rd_rdy) w_rd_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rd_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  cache_axi_wr_ch #(
    .WR_ID    (WR_ID),
    .LINE_LEN (LINE_LEN)
  ) u_wr_ch (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .busy     (w_wr_busy),
    .buf_line (w_wbuf_line),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wid      (wid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready)
  );

endmodule
`default_nettype wire
